// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - MEM-stage data-memory bridge onto a valid/ready request bus with response channel and watchdog
module dmem_bridge #(
    parameter int TIMEOUT = 255,
    parameter int TCW     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [3:0]  byteEnable,
    output logic [31:0] RD_data,
    output logic        StallM,
    output logic        bus_err,
    output logic        req_valid,
    input  logic        req_ready,
    output logic        req_we,
    output logic [31:0] req_addr,
    output logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    // Abort fires in the TIMEOUT-th cycle spent in REQ+WAIT, so DONE lands
    // exactly TIMEOUT cycles after entering REQ.
    localparam logic [TCW-1:0] LIMIT = TCW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t         state;
    state_t         state_nxt;
    logic [TCW-1:0] tmo_cnt;
    logic           acc;
    logic           is_write;
    logic           tmo_hit;
    logic           abort;

    // A store with no enabled lanes is not an access at all.
    assign is_write = MemWriteM & (|byteEnable);
    assign acc      = MemReadM | is_write;

    // Comparison is >= so a handshake that wins the race at the limit cannot
    // leave the counter past LIMIT with no way to abort later.
    assign tmo_hit  = (tmo_cnt >= LIMIT);

    // Pipeline is released only in DONE; the next IDLE sees a new instruction.
    assign StallM   = acc & (state != S_DONE);

    // Next-state decode; a normal handshake takes priority over the watchdog.
    always_comb begin
        state_nxt = state;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                if (acc) begin
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (req_ready) begin
                    state_nxt = S_WAIT;
                end else if (tmo_hit) begin
                    state_nxt = S_DONE;
                    abort     = 1'b1;
                end
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    state_nxt = S_DONE;
                end else if (tmo_hit) begin
                    state_nxt = S_DONE;
                    abort     = 1'b1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Watchdog counter: cleared on launch, saturating count through REQ and WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE) begin
            if (acc) begin
                tmo_cnt <= '0;
            end
        end else if (state == S_REQ || state == S_WAIT) begin
            if (tmo_cnt != {TCW{1'b1}}) begin
                tmo_cnt <= tmo_cnt + TCW'(1);
            end
        end
    end

    // Request fields are latched once at launch and held until the next launch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_valid <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_be    <= '0;
        end else begin
            req_valid <= (state_nxt == S_REQ);
            if (state == S_IDLE && acc) begin
                req_we    <= is_write;
                req_addr  <= {ALUResultM[31:2], 2'b00};
                req_wdata <= WriteDataM << {ALUResultM[1:0], 3'b000};
                req_be    <= is_write ? byteEnable : 4'b1111;
            end
        end
    end

    // Read capture and abort reporting; write acknowledges leave RD_data alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RD_data <= '0;
            bus_err <= 1'b0;
        end else begin
            bus_err <= abort;
            if (abort) begin
                RD_data <= '0;
            end else if (state == S_WAIT && rsp_valid && !req_we) begin
                RD_data <= rsp_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - directed self-checking bench for dmem_bridge
module tb_dmem_bridge;

    logic        clk;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [31:0] ALUResultM, WriteDataM;
    logic [3:0]  byteEnable;
    logic [31:0] RD_data;
    logic        StallM, bus_err, req_valid, req_ready, req_we, rsp_valid;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_be;

    logic        t_MemReadM, t_MemWriteM;
    logic [31:0] t_ALUResultM, t_WriteDataM;
    logic [3:0]  t_byteEnable;
    logic [31:0] t_RD_data;
    logic        t_StallM, t_bus_err, t_req_valid, t_req_ready, t_req_we, t_rsp_valid;
    logic [31:0] t_req_addr, t_req_wdata, t_rsp_rdata;
    logic [3:0]  t_req_be;

    int total = 0;
    int bad   = 0;

    dmem_bridge dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .byteEnable(byteEnable),
        .RD_data(RD_data), .StallM(StallM), .bus_err(bus_err),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata)
    );

    dmem_bridge #(.TIMEOUT(5)) dut_to (
        .clk(clk), .reset(reset),
        .MemReadM(t_MemReadM), .MemWriteM(t_MemWriteM),
        .ALUResultM(t_ALUResultM), .WriteDataM(t_WriteDataM), .byteEnable(t_byteEnable),
        .RD_data(t_RD_data), .StallM(t_StallM), .bus_err(t_bus_err),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_we(t_req_we),
        .req_addr(t_req_addr), .req_wdata(t_req_wdata), .req_be(t_req_be),
        .rsp_valid(t_rsp_valid), .rsp_rdata(t_rsp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one access on dut from IDLE; slave raises req_ready after ready_dly
    // REQ cycles and rsp_valid rsp_dly cycles after acceptance (-1 = never).
    task automatic do_access(
        input  logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
        input  logic [3:0] be, input int ready_dly, input int rsp_dly, input logic [31:0] rdata,
        output int stalls, output int hs, output int errs, output int done_cyc,
        output logic [31:0] rd_done, output logic unstable,
        output logic [31:0] f_addr, output logic [31:0] f_wdata, output logic [3:0] f_be,
        output logic f_we, output logic post_rv
    );
        int   req_cycles;
        int   acc_cyc;
        logic seen;
        stalls = 0; hs = 0; errs = 0; done_cyc = -1; rd_done = '0; unstable = 1'b0;
        f_addr = '0; f_wdata = '0; f_be = '0; f_we = 1'b0; post_rv = 1'b0;
        req_cycles = 0; acc_cyc = -1; seen = 1'b0;
        MemReadM = rd; MemWriteM = wr; ALUResultM = addr; WriteDataM = wd; byteEnable = be;
        req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = rdata;
        for (int cyc = 0; cyc < 400; cyc++) begin
            #1;
            if (bus_err) errs++;
            if (!StallM) begin
                done_cyc = cyc;
                rd_done  = RD_data;
                break;
            end
            stalls++;
            req_ready = 1'b0;
            rsp_valid = 1'b0;
            if (req_valid) begin
                if (!seen) begin
                    seen = 1'b1;
                    f_addr = req_addr; f_wdata = req_wdata; f_be = req_be; f_we = req_we;
                end else if (req_addr !== f_addr || req_wdata !== f_wdata ||
                             req_be !== f_be || req_we !== f_we) begin
                    unstable = 1'b1;
                end
                if (req_cycles >= ready_dly) begin
                    req_ready = 1'b1;
                    hs++;
                    acc_cyc = cyc;
                end
                req_cycles++;
            end
            if (acc_cyc >= 0 && rsp_dly >= 0 && cyc - acc_cyc == rsp_dly) rsp_valid = 1'b1;
            step();
        end
        MemReadM = 1'b0; MemWriteM = 1'b0; byteEnable = 4'b0000;
        req_ready = 1'b0; rsp_valid = 1'b0;
        step();
        post_rv = req_valid;
        if (bus_err) errs++;
    endtask

    // Runs one access on dut_to from IDLE; returns the cycle index of DONE.
    task automatic run_to(input int rdy_at, input int rsp_at, input logic [31:0] rdata,
                          output int cyc);
        cyc = 0;
        t_MemReadM = 1'b1; t_ALUResultM = 32'h0000_0500; t_rsp_rdata = rdata;
        t_req_ready = 1'b0; t_rsp_valid = 1'b0;
        #1;
        while (t_StallM && cyc < 50) begin
            t_req_ready = (cyc == rdy_at);
            t_rsp_valid = (cyc == rsp_at);
            step();
            cyc++;
        end
        t_req_ready = 1'b0; t_rsp_valid = 1'b0;
    endtask

    int          st, hs, er, dc;
    logic [31:0] rdd, fa, fw;
    logic [3:0]  fb;
    logic        un, fwe, prv;

    task automatic test_reset();
        reset = 1'b0;
        MemReadM = 1'b1; MemWriteM = 1'b0; ALUResultM = 32'h0000_0040; WriteDataM = '0;
        byteEnable = 4'b0000; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0;
        t_MemReadM = 1'b0; t_MemWriteM = 1'b0; t_ALUResultM = '0; t_WriteDataM = '0;
        t_byteEnable = 4'b0000; t_req_ready = 1'b0; t_rsp_valid = 1'b0; t_rsp_rdata = '0;
        step(); step();
        total++; if (req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b want=0", req_valid); end
        total++; if (req_we !== 1'b0) begin bad++; $display("FAIL reset_req_we got=%b want=0", req_we); end
        total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err got=%b want=0", bus_err); end
        total++; if (req_addr !== 32'h0 || req_wdata !== 32'h0 || req_be !== 4'h0) begin
            bad++; $display("FAIL reset_req_fields got=%h/%h/%h want=0/0/0", req_addr, req_wdata, req_be); end
        total++; if (RD_data !== 32'h0) begin bad++; $display("FAIL reset_rd_data got=%h want=0", RD_data); end
        total++; if (StallM !== 1'b1) begin bad++; $display("FAIL reset_stall_acc got=%b want=1", StallM); end
        MemReadM = 1'b0;
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL reset_stall_noacc got=%b want=0", StallM); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_read();
        do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 4'b0000, 0, 1, 32'hCAFE_BABE,
                  st, hs, er, dc, rdd, un, fa, fw, fb, fwe, prv);
        total++; if (fa !== 32'h0000_0100) begin bad++; $display("FAIL read_addr got=%h want=00000100", fa); end
        total++; if (fb !== 4'b1111 || fwe !== 1'b0) begin bad++; $display("FAIL read_be_we got=%b/%b want=1111/0", fb, fwe); end
        total++; if (st !== 3) begin bad++; $display("FAIL read_stalls got=%0d want=3", st); end
        total++; if (dc !== 3) begin bad++; $display("FAIL read_done_cycle got=%0d want=3", dc); end
        total++; if (rdd !== 32'hCAFE_BABE) begin bad++; $display("FAIL read_rd_data got=%h want=cafebabe", rdd); end
        total++; if (hs !== 1 || er !== 0) begin bad++; $display("FAIL read_hs_err got=%0d/%0d want=1/0", hs, er); end
    endtask

    task automatic test_stores();
        do_access(1'b0, 1'b1, 32'h0000_0203, 32'h0000_00A5, 4'b1000, 0, 1, 32'hFFFF_FFFF,
                  st, hs, er, dc, rdd, un, fa, fw, fb, fwe, prv);
        total++; if (fw !== 32'hA500_0000 || fb !== 4'b1000 || fwe !== 1'b1) begin
            bad++; $display("FAIL sb3_fields got=%h/%b/%b want=a5000000/1000/1", fw, fb, fwe); end
        total++; if (fa !== 32'h0000_0200) begin bad++; $display("FAIL sb3_addr got=%h want=00000200", fa); end
        total++; if (rdd !== 32'hCAFE_BABE) begin bad++; $display("FAIL store_keeps_rd got=%h want=cafebabe", rdd); end
        total++; if (dc !== 3) begin bad++; $display("FAIL sb3_done_cycle got=%0d want=3", dc); end
        do_access(1'b0, 1'b1, 32'h0000_0202, 32'h0000_1234, 4'b1100, 0, 1, 32'h0,
                  st, hs, er, dc, rdd, un, fa, fw, fb, fwe, prv);
        total++; if (fw !== 32'h1234_0000 || fb !== 4'b1100) begin
            bad++; $display("FAIL sh2_fields got=%h/%b want=12340000/1100", fw, fb); end
        do_access(1'b0, 1'b1, 32'h0000_0201, 32'h0000_005A, 4'b0010, 0, 1, 32'h0,
                  st, hs, er, dc, rdd, un, fa, fw, fb, fwe, prv);
        total++; if (fw !== 32'h0000_5A00 || fb !== 4'b0010) begin
            bad++; $display("FAIL sb1_fields got=%h/%b want=00005a00/0010", fw, fb); end
        do_access(1'b1, 1'b1, 32'h0000_0300, 32'h0000_0077, 4'b0001, 0, 1, 32'h0,
                  st, hs, er, dc, rdd, un, fa, fw, fb, fwe, prv);
        total++; if (fwe !== 1'b1 || fb !== 4'b0001 || fw !== 32'h0000_0077) begin
            bad++; $display("FAIL rw_priority got=%b/%b/%h want=1/0001/00000077", fwe, fb, fw); end
    endtask

    task automatic test_backpressure();
        do_access(1'b1, 1'b0, 32'h0000_0406, 32'h0, 4'b0000, 4, 3, 32'h1357_9BDF,
                  st, hs, er, dc, rdd, un, fa, fw, fb, fwe, prv);
        total++; if (st !== 9) begin bad++; $display("FAIL bp_stalls got=%0d want=9", st); end
        total++; if (hs !== 1) begin bad++; $display("FAIL bp_handshakes got=%0d want=1", hs); end
        total++; if (un !== 1'b0) begin bad++; $display("FAIL bp_stable got=%b want=0", un); end
        total++; if (fa !== 32'h0000_0404) begin bad++; $display("FAIL bp_addr got=%h want=00000404", fa); end
        total++; if (rdd !== 32'h1357_9BDF || er !== 0) begin
            bad++; $display("FAIL bp_rd_err got=%h/%0d want=13579bdf/0", rdd, er); end
    endtask

    task automatic test_timeout();
        int cyc;
        run_to(1, 2, 32'h1111_2222, cyc);
        total++; if (cyc !== 3 || t_RD_data !== 32'h1111_2222) begin
            bad++; $display("FAIL to_prime got=%0d/%h want=3/11112222", cyc, t_RD_data); end
        t_MemReadM = 1'b0; step();
        run_to(-1, -1, 32'h0, cyc);
        total++; if (cyc !== 6) begin bad++; $display("FAIL to_done_cycle got=%0d want=6", cyc); end
        total++; if (t_bus_err !== 1'b1) begin bad++; $display("FAIL to_bus_err got=%b want=1", t_bus_err); end
        total++; if (t_RD_data !== 32'h0) begin bad++; $display("FAIL to_rd_zero got=%h want=0", t_RD_data); end
        total++; if (t_req_valid !== 1'b0 || t_StallM !== 1'b0) begin
            bad++; $display("FAIL to_done_outputs got=%b/%b want=0/0", t_req_valid, t_StallM); end
        t_MemReadM = 1'b0; step();
        total++; if (t_bus_err !== 1'b0 || t_req_valid !== 1'b0) begin
            bad++; $display("FAIL to_after_done got=%b/%b want=0/0", t_bus_err, t_req_valid); end
        run_to(5, 6, 32'h3333_4444, cyc);
        total++; if (cyc !== 7 || t_bus_err !== 1'b0 || t_RD_data !== 32'h3333_4444) begin
            bad++; $display("FAIL to_race got=%0d/%b/%h want=7/0/33334444", cyc, t_bus_err, t_RD_data); end
        t_MemReadM = 1'b0; step();
    endtask

    task automatic test_drop_and_reset();
        int rv_seen;
        rv_seen = 0;
        MemWriteM = 1'b1; byteEnable = 4'b0000; ALUResultM = 32'h0000_0600; WriteDataM = 32'hFFFF_FFFF;
        #1;
        total++; if (StallM !== 1'b0) begin bad++; $display("FAIL drop_stall got=%b want=0", StallM); end
        for (int i = 0; i < 3; i++) begin step(); if (req_valid) rv_seen++; end
        total++; if (rv_seen !== 0) begin bad++; $display("FAIL drop_req_valid got=%0d want=0", rv_seen); end
        MemWriteM = 1'b0;
        MemReadM = 1'b1; ALUResultM = 32'h0000_0700; req_ready = 1'b1;
        step();
        step();
        req_ready = 1'b0;
        #1;
        total++; if (StallM !== 1'b1) begin bad++; $display("FAIL rst_wait_stall got=%b want=1", StallM); end
        reset = 1'b0; MemReadM = 1'b0;
        #1;
        total++; if (req_valid !== 1'b0 || RD_data !== 32'h0 || StallM !== 1'b0) begin
            bad++; $display("FAIL rst_async got=%b/%h/%b want=0/0/0", req_valid, RD_data, StallM); end
        step();
        reset = 1'b1;
        rsp_valid = 1'b1; rsp_rdata = 32'hDEAD_BEEF;
        rv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            rsp_valid = 1'b0;
            if (req_valid || bus_err || StallM || RD_data !== 32'h0) rv_seen++;
        end
        total++; if (rv_seen !== 0) begin bad++; $display("FAIL rst_late_rsp got=%0d want=0", rv_seen); end
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 32'h0000_0800, 32'h0, 4'b0000, 0, 1, 32'hAAAA_5555,
                  st, hs, er, dc, rdd, un, fa, fw, fb, fwe, prv);
        total++; if (hs !== 1 || dc !== 3 || fa !== 32'h0000_0800 || fwe !== 1'b0) begin
            bad++; $display("FAIL b2b_first got=%0d/%0d/%h/%b want=1/3/00000800/0", hs, dc, fa, fwe); end
        do_access(1'b0, 1'b1, 32'h0000_0804, 32'h0102_0304, 4'b1111, 0, 1, 32'h0,
                  st, hs, er, dc, rdd, un, fa, fw, fb, fwe, prv);
        total++; if (hs !== 1 || dc !== 3 || fa !== 32'h0000_0804 || fwe !== 1'b1) begin
            bad++; $display("FAIL b2b_second got=%0d/%0d/%h/%b want=1/3/00000804/1", hs, dc, fa, fwe); end
        total++; if (fw !== 32'h0102_0304 || rdd !== 32'hAAAA_5555) begin
            bad++; $display("FAIL b2b_data got=%h/%h want=01020304/aaaa5555", fw, rdd); end
        total++; if (prv !== 1'b0 || er !== 0) begin
            bad++; $display("FAIL b2b_no_dup got=%b/%0d want=0/0", prv, er); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_stores();
        test_backpressure();
        test_timeout();
        test_drop_and_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
